// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer with HI/LO register file for the MIPS E stage.
// The full result is computed at the start edge, then held in pend regs until the busy window expires.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    logic [63:0] rs_sext, rt_sext;
    logic [63:0] prod_s, prod_u;
    logic [31:0] rs_mag, rt_mag, rt_mag_safe, rt_safe;
    logic [31:0] mag_q, mag_r;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        div_by_zero;

    // Signed division is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    always_comb begin
        rs_sext     = {{32{rs_val[31]}}, rs_val};
        rt_sext     = {{32{rt_val[31]}}, rt_val};
        prod_s      = rs_sext * rt_sext;
        prod_u      = {32'd0, rs_val} * {32'd0, rt_val};

        div_by_zero = (rt_val == 32'd0);
        rt_safe     = div_by_zero ? 32'd1 : rt_val;
        quo_u       = rs_val / rt_safe;
        rem_u       = rs_val % rt_safe;

        rs_mag      = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
        rt_mag      = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
        rt_mag_safe = div_by_zero ? 32'd1 : rt_mag;
        mag_q       = rs_mag / rt_mag_safe;
        mag_r       = rs_mag % rt_mag_safe;
        quo_s       = (rs_val[31] ^ rt_val[31]) ? (~mag_q + 32'd1) : mag_q;
        rem_s       = rs_val[31] ? (~mag_r + 32'd1) : mag_r;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            cnt_d     = MULT_CNT;
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            cnt_d     = MULT_CNT;
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d = div_by_zero ? hi_q : rem_s;
                            pend_lo_d = div_by_zero ? lo_q : quo_s;
                            cnt_d     = DIV_CNT;
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d = div_by_zero ? hi_q : rem_u;
                            pend_lo_d = div_by_zero ? lo_q : quo_u;
                            cnt_d     = DIV_CNT;
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: busy window, HI/LO results, ignored ops, async reset.
module tb_md_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    md_sequencer #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Holds start high across exactly one rising edge, returning at the next falling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        start  = 1'b1;
        md_op  = op;
        rs_val = rs;
        rt_val = rt;
        @(negedge clk);
        start  = 1'b0;
        md_op  = 3'd7;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input int n, input logic [31:0] oldHi, input logic [31:0] oldLo,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        applyStimulus(op, rs, rt);
        for (int i = 1; i <= n; i++) begin
            checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, "_hold_hi"}, hi, oldHi);
            checkOutput({tag, "_hold_lo"}, lo, oldLo);
            @(negedge clk);
        end
        checkOutput({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_lo"}, lo, expLo);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        md_op  = 3'd7;
        rs_val = 32'd0;
        rt_val = 32'd0;

        #2;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        runOp("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        runOp("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'h00000001);
        runOp("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0, 32'h80000000);

        applyStimulus(3'd4, 32'h11, 32'd0);
        checkOutput("mthi_hi", hi, 32'h11);
        checkOutput("mthi_lo", lo, 32'h80000000);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
        applyStimulus(3'd5, 32'h22, 32'd0);
        checkOutput("mtlo_hi", hi, 32'h11);
        checkOutput("mtlo_lo", lo, 32'h22);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);

        runOp("divu0", 3'd3, 32'h1234, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);

        applyStimulus(3'd6, 32'hABCD, 32'h5);
        checkOutput("nop6_busy", {31'd0, busy}, 32'd0);
        checkOutput("nop6_hi", hi, 32'h11);
        applyStimulus(3'd7, 32'hABCD, 32'h5);
        checkOutput("nop7_busy", {31'd0, busy}, 32'd0);
        checkOutput("nop7_lo", lo, 32'h22);

        applyStimulus(3'd0, 32'd5, 32'd7);
        checkOutput("ign_c1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd5;
        rs_val = 32'hDEAD;
        @(negedge clk);
        checkOutput("ign_c3_lo", lo, 32'h22);
        md_op  = 3'd0;
        rs_val = 32'd9;
        rt_val = 32'd9;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd7;
        checkOutput("ign_c4_busy", {31'd0, busy}, 32'd1);
        checkOutput("ign_c4_lo", lo, 32'h22);
        @(negedge clk);
        checkOutput("ign_c5_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("ign_c6_busy", {31'd0, busy}, 32'd0);
        checkOutput("ign_hi", hi, 32'd0);
        checkOutput("ign_lo", lo, 32'd35);
        @(negedge clk);
        checkOutput("ign_c7_busy", {31'd0, busy}, 32'd0);
        checkOutput("ign_c7_lo", lo, 32'd35);

        applyStimulus(3'd2, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_async_hi", hi, 32'd0);
        checkOutput("rst_async_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_after_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_after_lo", lo, 32'd0);

        runOp("mult2", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
